// File: rtl/argon_lsu.sv
// Single-outstanding load/store unit between a CPU request port and a fixed-latency memory.
// Optional local misalignment detection: define ARGON_LSU_MISALIGN_CHECK_EN.
module argon_lsu #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic [1:0]  o_resp_err,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_err_address_misaligned,
  input  logic        i_mem_err_invalid_read_mask
);

  localparam logic [1:0] CNT_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  err_acc;
  logic [1:0]  cnt;
  logic [1:0]  local_err_c;
  logic [1:0]  err_now_c;
  logic [31:0] wdata_c;

  // Requests rejected without touching memory
  always_comb begin
    local_err_c = 2'b00;
    if (i_req_size == 2'b11) begin
      local_err_c = 2'b10;
    end
`ifdef ARGON_LSU_MISALIGN_CHECK_EN
    else if ((i_req_size == 2'b01 && i_req_addr[0]) ||
             (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00)) begin
      local_err_c = 2'b01;
    end
`endif
  end

  always_comb begin
    case (i_req_size)
      2'b00:   wdata_c = {24'h0, i_req_wdata[7:0]};
      2'b01:   wdata_c = {16'h0, i_req_wdata[15:0]};
      default: wdata_c = i_req_wdata;
    endcase
  end

  assign err_now_c = err_acc | {i_mem_err_invalid_read_mask, i_mem_err_address_misaligned};

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'b00:   extend = uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   extend = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= IDLE;
      o_req_ready   <= 1'b1;
      o_resp_valid  <= 1'b0;
      o_resp_rdata  <= 32'h0;
      o_resp_err    <= 2'b00;
      o_mem_address <= 32'h0;
      o_mem_wr_data <= 32'h0;
      o_mem_wr_mask <= 2'b00;
      o_mem_rd_mask <= 3'b000;
      wr_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'b00;
      err_acc       <= 2'b00;
      cnt           <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            wr_q        <= i_req_write;
            uns_q       <= i_req_unsigned;
            size_q      <= i_req_size;
            err_acc     <= 2'b00;
            cnt         <= 2'b00;
            if (local_err_c != 2'b00) begin
              state        <= RESP;
              o_resp_valid <= 1'b1;
              o_resp_err   <= local_err_c;
              o_resp_rdata <= 32'h0;
            end else begin
              state         <= ISSUE;
              o_mem_address <= i_req_addr;
              if (i_req_write) begin
                o_mem_wr_data <= wdata_c;
                o_mem_wr_mask <= i_req_size + 2'd1;
              end else begin
                o_mem_rd_mask <= 3'(3'b001 << i_req_size);
              end
            end
          end
        end
        ISSUE: begin
          o_mem_wr_mask <= 2'b00;
          o_mem_rd_mask <= 3'b000;
          if (wr_q) begin
            state        <= RESP;
            o_resp_valid <= 1'b1;
            o_resp_err   <= err_now_c;
            o_resp_rdata <= 32'h0;
          end else begin
            state   <= WAIT;
            err_acc <= err_now_c;
            cnt     <= 2'b00;
          end
        end
        WAIT: begin
          err_acc <= err_now_c;
          // Data is valid RD_LATENCY cycles after the ISSUE cycle
          if (cnt == CNT_LAST) begin
            state        <= RESP;
            cnt          <= 2'b00;
            o_resp_valid <= 1'b1;
            o_resp_err   <= err_now_c;
            o_resp_rdata <= (err_now_c != 2'b00) ? 32'h0 : extend(i_mem_rd_data, size_q, uns_q);
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            state        <= IDLE;
            o_resp_valid <= 1'b0;
            o_req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argon_lsu.sv
// Bench for argon_lsu: two instances (RD_LATENCY 1 and 3), directed and random
// transactions checked against a behavioural transaction model.
module tb_argon_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [1:0]  req_size   [2];
  logic        req_uns    [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_err   [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wd     [2];
  logic [1:0]  mem_wm     [2];
  logic [2:0]  mem_rm     [2];
  logic [31:0] mem_rd     [2];
  logic        mem_mis    [2];
  logic        mem_inv    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    argon_lsu #(.RD_LATENCY((g == 0) ? 1 : 3)) dut (
      .i_clk(clk),
      .i_reset(rst[g]),
      .i_req_valid(req_valid[g]),
      .o_req_ready(req_ready[g]),
      .i_req_write(req_write[g]),
      .i_req_size(req_size[g]),
      .i_req_unsigned(req_uns[g]),
      .i_req_addr(req_addr[g]),
      .i_req_wdata(req_wdata[g]),
      .o_resp_valid(resp_valid[g]),
      .i_resp_ready(resp_ready[g]),
      .o_resp_rdata(resp_rdata[g]),
      .o_resp_err(resp_err[g]),
      .o_mem_address(mem_addr[g]),
      .o_mem_wr_data(mem_wd[g]),
      .o_mem_wr_mask(mem_wm[g]),
      .o_mem_rd_mask(mem_rm[g]),
      .i_mem_rd_data(mem_rd[g]),
      .i_mem_err_address_misaligned(mem_mis[g]),
      .i_mem_err_invalid_read_mask(mem_inv[g])
    );
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rdata;
  logic [1:0]  last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // One full transaction on instance d; memory answers exactly RD_LATENCY cycles after ISSUE
  task automatic txn(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] mdata, input bit inv, input int hold);
    int lat, exp_cyc, n, strobes, s_cyc;
    bit misal, access, load, got, busy_ok, stable_ok;
    logic [1:0]  exp_err, exp_wm, s_wm;
    logic [2:0]  exp_rm, s_rm;
    logic [31:0] exp_rd, exp_wd, v, s_addr, s_wd;
    lat = lat_of(d);
    misal = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
    access = 1'b1;
    exp_err = 2'b00;
    if (sz == 2'd3) begin
      exp_err = 2'b10;
      access = 1'b0;
    end
`ifdef ARGON_LSU_MISALIGN_CHECK_EN
    else if (misal) begin
      exp_err = 2'b01;
      access = 1'b0;
    end
`endif
    load = access && !wr;
    if (access) exp_err = {load && inv, misal};
    exp_cyc = !access ? 1 : (wr ? 2 : 2 + lat);
    exp_wm = !wr ? 2'd0 : (sz == 2'd0) ? 2'd1 : (sz == 2'd1) ? 2'd2 : 2'd3;
    exp_rm = wr ? 3'd0 : (sz == 2'd0) ? 3'd1 : (sz == 2'd1) ? 3'd2 : 3'd4;
    exp_wd = (sz == 2'd0) ? wdata % 256 : (sz == 2'd1) ? wdata % 65536 : wdata;
    exp_rd = 32'h0;
    if (load && exp_err == 2'b00) begin
      if (sz == 2'd0) begin
        v = mdata % 256;
        if (!uns && v >= 128) v = v - 256;
      end else if (sz == 2'd1) begin
        v = mdata % 65536;
        if (!uns && v >= 32768) v = v - 65536;
      end else begin
        v = mdata;
      end
      exp_rd = v;
    end

    chk("ready_before_req", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_size[d]  = sz;
    req_uns[d]   = uns;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    step();
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_size[d]  = 2'($urandom);
    req_write[d] = ~wr;

    n = 1; got = 1'b0; strobes = 0; busy_ok = 1'b1;
    s_cyc = 0; s_wm = 2'b00; s_rm = 3'b000; s_addr = 32'h0; s_wd = 32'h0;
    while (!got && n <= 20) begin
      if (resp_valid[d]) begin
        got = 1'b1;
      end else begin
        if (req_ready[d]) busy_ok = 1'b0;
        if (mem_wm[d] != 2'b00 || mem_rm[d] != 3'b000) begin
          strobes++;
          s_cyc = n; s_wm = mem_wm[d]; s_rm = mem_rm[d];
          s_addr = mem_addr[d]; s_wd = mem_wd[d];
        end
        mem_mis[d] = access && misal && n == 1;
        mem_inv[d] = load && inv && n == 1 + lat;
        mem_rd[d]  = (n == 1 + lat) ? mdata : $urandom;
        step();
        n++;
      end
    end
    mem_mis[d] = 1'b0;
    mem_inv[d] = 1'b0;
    mem_rd[d]  = $urandom;
    chk("resp_timeout", 32'(got), 32'd1);
    if (!got) return;

    chk("resp_latency", 32'(n), 32'(exp_cyc));
    chk("strobe_count", 32'(strobes), access ? 32'd1 : 32'd0);
    if (access) begin
      chk("strobe_cycle", 32'(s_cyc), 32'd1);
      chk("wr_mask", 32'(s_wm), 32'(exp_wm));
      chk("rd_mask", 32'(s_rm), 32'(exp_rm));
      chk("mem_address", s_addr, addr);
      if (wr) chk("mem_wr_data", s_wd, exp_wd);
    end
    chk("masks_off_in_resp", {mem_wm[d], mem_rm[d]}, 32'd0);
    chk("resp_rdata", resp_rdata[d], exp_rd);
    chk("resp_err", 32'(resp_err[d]), 32'(exp_err));
    chk("busy_not_ready", 32'(busy_ok), 32'd1);
    last_rdata = resp_rdata[d];
    last_err = resp_err[d];

    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!resp_valid[d] || resp_rdata[d] !== exp_rd || resp_err[d] !== exp_err || req_ready[d])
        stable_ok = 1'b0;
    end
    if (hold > 0) chk("resp_stable", 32'(stable_ok), 32'd1);
    resp_ready[d] = 1'b1;
    step();
    resp_ready[d] = 1'b0;
    chk("valid_drop", 32'(resp_valid[d]), 32'd0);
    chk("ready_after_resp", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    bit ok;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b1; req_write[d] = 1'b0; req_size[d] = 2'd0;
      req_uns[d] = 1'b0; req_addr[d] = 32'h55; req_wdata[d] = 32'h0; resp_ready[d] = 1'b0;
      mem_rd[d] = 32'h0; mem_mis[d] = 1'b0; mem_inv[d] = 1'b0;
    end
    step(); step(); step();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      req_valid[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_rdata_err", resp_rdata[d] | 32'(resp_err[d]), 32'd0);
      chk("rst_mem_addr_wd", mem_addr[d] | mem_wd[d], 32'd0);
      chk("rst_masks", {mem_wm[d], mem_rm[d]}, 32'd0);
    end

    txn(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    txn(0, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h00000080, 1'b0, 0);
    chk("byte_signed_value", last_rdata, 32'hFFFFFF80);
    txn(0, 1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 32'h00000080, 1'b0, 1);
    chk("byte_unsigned_value", last_rdata, 32'h00000080);
    txn(0, 1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 32'h0000BEEF, 1'b0, 0);
    chk("half_misaligned_err", 32'(last_err), 32'd1);
    chk("half_misaligned_rdata", last_rdata, 32'd0);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h12345678, 1'b0, 4);
    chk("lat3_word_value", last_rdata, 32'h12345678);
    txn(0, 1'b0, 2'd3, 1'b0, 32'h400, 32'h0, 32'hFFFFFFFF, 1'b0, 0);
    chk("size11_err", 32'(last_err), 32'd2);
    txn(1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 32'h00008001, 1'b1, 2);
    chk("invalid_mask_err", 32'(last_err), 32'd2);

    // Reset in the middle of a latency-3 load
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'd2; req_addr[1] = 32'h500;
    step();
    req_valid[1] = 1'b0;
    chk("abort_issue_mask", 32'(mem_rm[1]), 32'd4);
    step();
    rst[1] = 1'b0;
    req_valid[1] = 1'b1;
    step();
    rst[1] = 1'b1;
    req_valid[1] = 1'b0;
    chk("abort_ready", 32'(req_ready[1]), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_rd[1] = 32'hCAFE0000 + 32'(i);
      mem_mis[1] = 1'b1;
      mem_inv[1] = 1'b1;
      if (resp_valid[1] || mem_rm[1] != 3'd0 || mem_wm[1] != 2'd0 || !req_ready[1]) ok = 1'b0;
      step();
    end
    mem_mis[1] = 1'b0;
    mem_inv[1] = 1'b0;
    chk("abort_quiet", 32'(ok), 32'd1);
    chk("abort_err_clear", 32'(resp_err[1]), 32'd0);
    txn(1, 1'b1, 2'd0, 1'b0, 32'h600, 32'h123456A5, 32'h0, 1'b0, 0);

    for (int k = 0; k < 60; k++) begin
      txn(k % 2, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/argon_lsu.md
ARGON_LSU -- requirements
Module: argon_lsu

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, memory read-data latency in cycles (legal 1..4).
REQ-002 SHALL have ports i_clk, in, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port i_reset, in, 1, synchronous active-low reset.
REQ-004 SHALL have CPU request ports: i_req_valid in 1; o_req_ready out 1; i_req_write in 1; i_req_size in 2 (00 byte, 01 half, 10 word, 11 illegal); i_req_unsigned in 1 (load zero-extend); i_req_addr in 32; i_req_wdata in 32.
REQ-005 SHALL have CPU response ports: o_resp_valid out 1; i_resp_ready in 1; o_resp_rdata out 32; o_resp_err out 2 (bit0 misaligned, bit1 invalid size/mask).
REQ-006 SHALL have memory ports: o_mem_address out 32; o_mem_wr_data out 32; o_mem_wr_mask out 2 (00 none, 01 byte, 10 half, 11 word); o_mem_rd_mask out 3 (000 none, 001 byte, 010 half, 100 word); i_mem_rd_data in 32; i_mem_err_address_misaligned in 1; i_mem_err_invalid_read_mask in 1.

Function
REQ-007 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-008 SHALL assert o_req_ready only in IDLE; accept on i_req_valid & o_req_ready, latching write, size, unsigned, addr, wdata.
REQ-009 SHALL hold at most one outstanding request; no new accept until response handshake completes.
REQ-010 SHALL on accept go IDLE->ISSUE, except local error (REQ-017/018) goes IDLE->RESP with no memory strobe.
REQ-011 SHALL in ISSUE drive o_mem_address = latched addr and exactly one of o_mem_wr_mask/o_mem_rd_mask nonzero, for exactly one cycle.
REQ-012 SHALL place store data byte-lane 0 aligned: byte wdata[7:0], half wdata[15:0], word wdata[31:0], upper bits zero.
REQ-013 SHALL for stores go ISSUE->RESP, o_resp_rdata = 0.
REQ-014 SHALL for loads go ISSUE->WAIT, count RD_LATENCY-1 further cycles, sample i_mem_rd_data RD_LATENCY cycles after ISSUE, then go RESP.
REQ-015 SHALL extend loads: byte bits[7:0], half bits[15:0]; sign-extend unless unsigned latched; word passes unchanged.
REQ-016 SHALL OR i_mem_err_address_misaligned into err bit0 and i_mem_err_invalid_read_mask into bit1 if asserted in any ISSUE/WAIT cycle of the transaction.
REQ-017 SHALL flag size 11 as err bit1 locally, no memory access.
REQ-018 SHALL treat half with addr[0]=1 or word with addr[1:0]!=00 per REQ-025.
REQ-019 SHALL in RESP hold o_resp_valid=1 and o_resp_rdata/o_resp_err stable until i_resp_ready; on handshake go IDLE (next accept earliest following cycle).
REQ-020 SHALL drive o_mem_wr_mask, o_mem_rd_mask = 0 outside ISSUE; o_mem_address, o_mem_wr_data hold last value.
REQ-021 SHALL on error responses drive o_resp_rdata = 0.

Reset
REQ-022 SHALL when i_reset=0 at a clock edge force IDLE, o_resp_valid=0, o_resp_err=0, o_resp_rdata=0, o_mem_address=0, o_mem_wr_data=0, both masks=0, latency counter=0; o_req_ready=1 first cycle after release.
REQ-023 SHALL abort any in-flight transaction on reset with no response issued and drop late memory data/errors.
REQ-024 SHALL ignore i_req_valid while i_reset=0.

Configuration
REQ-025 SHALL with ARGON_LSU_MISALIGN_CHECK_EN defined detect REQ-018 misalignment locally: IDLE->RESP, err=01, no strobe; undefined: issue request unchanged, rely on memory error inputs.

Verification
REQ-026 Word store addr 0x100 data 0xDEADBEEF -> one ISSUE cycle, wr_mask=11, wr_data=0xDEADBEEF, rd_mask=000, resp err=00.
REQ-027 Signed byte load addr 0x101, mem data 0x00000080, RD_LATENCY=1 -> rd_mask=001, resp 3 cycles after accept, rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-028 Half load addr 0x103 -> with macro: no strobe, err=01; without: rd_mask=010 issued, memory misaligned err=1 -> err=01, rdata=0.
REQ-029 RD_LATENCY=3, word load, i_resp_ready low 4 cycles -> data sampled 3 cycles after ISSUE, o_resp_valid/rdata stable 4 cycles, o_req_ready=0 throughout.
REQ-030 Reset low during WAIT of a load -> next cycle IDLE, masks=0, no o_resp_valid; later memory data ignored.
REQ-031 size=11 request -> no memory strobe, err=10, rdata=0.
